status_supervisor: RTL

//  Board-level supervisor for multi-channel shapool test/top wrappers. Qualifies PLL lock,

---
 rtl/status_supervisor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/status_supervisor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : status_supervisor                                            |
// | Description : PLL-lock qualification, multi-channel success latch,         |
// |               open-drain READY and status LED encoding.                    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module status_supervisor #(
  parameter int NUM_CHANNELS     = 4,
  parameter int CHANNEL_IDX_W    = 2,
  parameter int LOCK_HOLD_CYCLES = 1024,
  parameter int FAST_DIV_LOG2    = 20,
  parameter int SLOW_DIV_LOG2    = 23
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     pll_locked_in,
  input  logic [NUM_CHANNELS-1:0]  channel_busy_in,
  input  logic [NUM_CHANNELS-1:0]  channel_success_in,
  input  logic                     ack_in,
  output logic                     success_valid_out,
  output logic [CHANNEL_IDX_W-1:0] success_index_out,
  output wire                      ready_n_od_out,
  output logic                     status_led_n_out,
  output logic [1:0]               state_out
);

  localparam int LOCK_CNT_W = $clog2(LOCK_HOLD_CYCLES + 1);
  localparam logic [LOCK_CNT_W-1:0] C_LOCK_HOLD = LOCK_CNT_W'(LOCK_HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_LOCK_WAIT = 2'd0,
    ST_IDLE      = 2'd1,
    ST_RUNNING   = 2'd2,
    ST_FOUND     = 2'd3
  } state_t;

  state_t                   r_state;
  logic [SLOW_DIV_LOG2-1:0] r_div_cnt;
  logic [LOCK_CNT_W-1:0]    r_lock_cnt;
  logic                     r_valid;
  logic [CHANNEL_IDX_W-1:0] r_index;
  logic                     r_led_n;

  logic                     w_lock_ok;
  logic                     w_any_busy;
  logic                     w_any_success;
  logic [CHANNEL_IDX_W-1:0] w_win_idx;

  assign w_lock_ok     = (r_lock_cnt == C_LOCK_HOLD);
  assign w_any_busy    = |channel_busy_in;
  assign w_any_success = |channel_success_in;

  // Scan from the top down so the lowest set bit is the one that sticks.
  always_comb begin
    w_win_idx = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (channel_success_in[i]) begin
        w_win_idx = CHANNEL_IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + SLOW_DIV_LOG2'(1);
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_lock_cnt <= '0;
    end else if (!pll_locked_in) begin
      r_lock_cnt <= '0;
    end else if (!w_lock_ok) begin
      r_lock_cnt <= r_lock_cnt + LOCK_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state <= ST_LOCK_WAIT;
      r_valid <= 1'b0;
      r_index <= '0;
      r_led_n <= 1'b1;
    end else begin
      // LED follows the state one cycle late.
      case (r_state)
        ST_LOCK_WAIT: r_led_n <= ~r_div_cnt[FAST_DIV_LOG2-1];
        ST_IDLE:      r_led_n <= 1'b0;
        ST_RUNNING:   r_led_n <= ~r_div_cnt[SLOW_DIV_LOG2-1];
        default:      r_led_n <= 1'b1;
      endcase

      if (!pll_locked_in) begin
        r_state <= ST_LOCK_WAIT;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_LOCK_WAIT: begin
            if (w_lock_ok) begin
              r_state <= ST_IDLE;
            end
          end
          ST_IDLE, ST_RUNNING: begin
            if (w_any_success) begin
              r_state <= ST_FOUND;
              r_valid <= 1'b1;
              r_index <= w_win_idx;
            end else if (w_any_busy) begin
              r_state <= ST_RUNNING;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_FOUND: begin
            // A fresh success arriving with the ack replaces the result.
            if (ack_in) begin
              if (w_any_success) begin
                r_index <= w_win_idx;
              end else begin
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
              end
            end
          end
          default: begin
            r_state <= ST_LOCK_WAIT;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign success_valid_out = r_valid;
  assign success_index_out = r_index;
  assign status_led_n_out  = r_led_n;
  assign state_out         = r_state;
  assign ready_n_od_out    = (r_state == ST_FOUND) ? 1'b0 : 1'bz;

endmodule
`default_nettype wire
